// File: rtl/rv64i_top_mem.sv
// rv64i_top_mem: single-cycle RV64I-subset core with IMEM, DMEM, memory-mapped GPIO and JTAG bypass.
module rv64i_top_mem #(
  parameter int          nr_gpios       = 32,
  parameter int          instr_width    = 32,
  parameter int          imemdepth      = 256,
  parameter int          dmemdepth      = 256,
  parameter logic [63:0] GPIO_ADDR      = 64'h400,
  parameter string       IMEM_FILE      = "riscvtest.mem",
  parameter int          im_scan_length = 40
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tck_i,
  input  logic                trst_i,
  input  logic                tms_i,
  input  logic                tdi_i,
  output logic                tdo_o,
  inout  wire  [nr_gpios-1:0] gpio_io,
  output logic                cs_o
);
  localparam int IW = $clog2(imemdepth);
  localparam int DW = $clog2(dmemdepth);
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67,
                         OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13, OP_REG = 7'h33;
  logic [instr_width-1:0] imem [imemdepth];
  logic [63:0] dmem [dmemdepth];
  logic [63:0] regs [32];
  logic [63:0] pc, pc4, npc, wdata, alu_i, alu_r, addr, ld_data;
  logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1v, rs2v;
  logic [nr_gpios-1:0] gpio;
  logic [instr_width-1:0] instr;
  logic [6:0] op;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic [5:0] shamt;
  logic wen, st, take, gpio_hit, imm_ok, reg_ok;
  assign instr = imem[pc[IW+1:2]];
  assign op    = instr[6:0];
  assign rd    = instr[11:7];
  assign f3    = instr[14:12];
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];
  assign shamt = instr[25:20];
  assign imm_i = {{52{instr[31]}}, instr[31:20]};
  assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};
  assign imm_j = {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign rs1v  = rs1 == 5'd0 ? '0 : regs[rs1];
  assign rs2v  = rs2 == 5'd0 ? '0 : regs[rs2];
  assign pc4   = pc + 64'd4;
  assign addr     = rs1v + (op == OP_ST ? imm_s : imm_i);
  assign gpio_hit = addr == GPIO_ADDR;
  assign ld_data  = gpio_hit ? 64'(gpio) : dmem[addr[DW+2:3]];
  assign gpio_io  = gpio;
  always_comb begin
    case (f3)
      3'b000:  take = rs1v == rs2v;
      3'b001:  take = rs1v != rs2v;
      3'b100:  take = $signed(rs1v) < $signed(rs2v);
      3'b101:  take = $signed(rs1v) >= $signed(rs2v);
      default: take = 1'b0;
    endcase
  end
  always_comb begin
    case (f3)
      3'b000:  alu_i = rs1v + imm_i;
      3'b111:  alu_i = rs1v & imm_i;
      3'b110:  alu_i = rs1v | imm_i;
      3'b100:  alu_i = rs1v ^ imm_i;
      3'b001:  alu_i = rs1v << shamt;
      default: alu_i = instr[30] ? 64'($signed(rs1v) >>> shamt) : rs1v >> shamt;
    endcase
    imm_ok = f3 == 3'b001 ? instr[31:26] == 6'b0 :
             f3 == 3'b101 ? (instr[31:26] == 6'b0 || instr[31:26] == 6'b010000) :
             (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b100);
  end
  always_comb begin
    case (f3)
      3'b000:  alu_r = instr[30] ? rs1v - rs2v : rs1v + rs2v;
      3'b111:  alu_r = rs1v & rs2v;
      3'b110:  alu_r = rs1v | rs2v;
      3'b100:  alu_r = rs1v ^ rs2v;
      3'b001:  alu_r = rs1v << rs2v[5:0];
      default: alu_r = rs1v >> rs2v[5:0];
    endcase
    reg_ok = (instr[31:25] == 7'h00 && f3 != 3'b010 && f3 != 3'b011) ||
             (instr[31:25] == 7'h20 && f3 == 3'b000);
  end
  always_comb begin
    npc   = pc4;
    wen   = 1'b0;
    wdata = alu_i;
    st    = 1'b0;
    case (op)
      OP_LUI:   begin wen = 1'b1; wdata = imm_u; end
      OP_AUIPC: begin wen = 1'b1; wdata = pc + imm_u; end
      OP_JAL:   begin wen = 1'b1; wdata = pc4; npc = pc + imm_j; end
      OP_JALR:  if (f3 == 3'b000) begin wen = 1'b1; wdata = pc4; npc = {addr[63:1], 1'b0}; end
      OP_BR:    npc = take ? pc + imm_b : pc4;
      OP_LD:    begin wen = f3 == 3'b011; wdata = ld_data; end
      OP_ST:    st = f3 == 3'b011;
      OP_IMM:   wen = imm_ok;
      OP_REG:   begin wen = reg_ok; wdata = alu_r; end
      default:  wen = 1'b0;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc   <= '0;
      gpio <= '0;
      cs_o <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      pc   <= npc;
      cs_o <= st && gpio_hit;
      if (st && gpio_hit) gpio <= rs2v[nr_gpios-1:0];
      if (wen && rd != 5'd0) regs[rd] <= wdata;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i && st && !gpio_hit) dmem[addr[DW+2:3]] <= rs2v;
  end
`ifdef SCAN_IMEM_LOAD_EN
  logic [im_scan_length-1:0] scan;
  logic [7:0] wr_addr;
  logic [31:0] wr_data;
  logic tms_q, wr_tgl;
  logic [2:0] tgl_sync;
  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      scan    <= '0;
      tms_q   <= 1'b0;
      wr_tgl  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      tms_q <= tms_i;
      if (tms_i) scan <= {tdi_i, scan[im_scan_length-1:1]};
      if (tms_q && !tms_i) begin
        wr_tgl  <= ~wr_tgl;
        wr_addr <= scan[39:32];
        wr_data <= scan[31:0];
      end
    end
  end
  assign tdo_o = scan[0];
  always_ff @(posedge clk_i) begin
    tgl_sync <= {tgl_sync[1:0], wr_tgl};
    if (rst_i && (tgl_sync[2] ^ tgl_sync[1])) imem[wr_addr[IW-1:0]] <= wr_data;
  end
`else
  logic bypass;
  logic unused_jtag;
  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) bypass <= 1'b0;
    else bypass <= tdi_i;
  end
  assign tdo_o       = bypass;
  assign unused_jtag = tms_i & im_scan_length[0];
`endif
endmodule

// File: tb/tb_rv64i_top_mem.sv
// tb_rv64i_top_mem: directed programs with a GPIO scoreboard checked on every cs_o cycle.
module tb_rv64i_top_mem;
   logic clk = 1'b0, rst = 1'b1, tck = 1'b0, trst = 1'b0, tms = 1'b0, tdi = 1'b0;
   logic tdo, cs;
   wire [31:0] gpio;
   int checks = 0, errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] prog[$];
   logic [31:0] e;
   rv64i_top_mem #(.IMEM_FILE("")) dut (
      .clk_i(clk), .rst_i(rst), .tck_i(tck), .trst_i(trst), .tms_i(tms), .tdi_i(tdi),
      .tdo_o(tdo), .gpio_io(gpio), .cs_o(cs)
   );
   always #5 clk = ~clk;
   function automatic logic [31:0] it(int imm, int rs1, int f3, int rd, int op);
      return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
   endfunction
   function automatic logic [31:0] addi(int rd, int rs1, int imm); return it(imm, rs1, 0, rd, 'h13); endfunction
   function automatic logic [31:0] slli(int rd, int rs1, int sh); return it(sh, rs1, 1, rd, 'h13); endfunction
   function automatic logic [31:0] srli(int rd, int rs1, int sh); return it(sh, rs1, 5, rd, 'h13); endfunction
   function automatic logic [31:0] srai(int rd, int rs1, int sh); return it(sh | 'h400, rs1, 5, rd, 'h13); endfunction
   function automatic logic [31:0] ld(int rd, int rs1, int imm); return it(imm, rs1, 3, rd, 'h03); endfunction
   function automatic logic [31:0] sd(int rs2, int rs1, int imm);
      return {imm[11:5], rs2[4:0], rs1[4:0], 3'b011, imm[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] rr(int f7, int rd, int rs1, int rs2, int f3);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
   endfunction
   function automatic logic [31:0] br(int f3, int rs1, int rs2, int imm);
      return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
   endfunction
   function automatic logic [31:0] jal(int rd, int imm);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
   endfunction
   function automatic logic [31:0] ut(int imm20, int rd, int op); return {imm20[19:0], rd[4:0], op[6:0]}; endfunction
   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (!rst && cs) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL gpio_pulse: unexpected cs_o with gpio_io=%h", gpio);
         end else begin
            e = exp_q.pop_front();
            if (gpio !== e) begin
               errors++;
               $display("FAIL gpio_pulse: gpio_io=%h expected %h", gpio, e);
            end
         end
      end
   end
   task automatic run(string name, int cycles, bit load);
      rst = 1'b1;
      @(negedge clk);
      if (load) begin
         for (int i = 0; i < 256; i++) dut.imem[i] = 32'h0;
         foreach (prog[i]) dut.imem[i] = prog[i];
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (cycles) @(negedge clk);
      chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask
   task automatic tck_pulse(logic d);
      tdi = d;
      #2 tck = 1'b1;
      #2 tck = 1'b0;
      #1;
   endtask
   initial begin
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("reset_pc", dut.pc, 64'd0);
      chk("reset_cs", 64'(cs), 64'd0);
      chk("reset_gpio", 64'(gpio), 64'd0);
      prog = {addi(1, 0, 1), slli(2, 1, 2), sd(2, 0, 'h400), jal(0, 0)};
      exp_q = {32'h4};
      run("slli", 20, 1'b1);
      prog = {addi(1, 0, 1), slli(2, 1, 63), srli(3, 2, 63), sd(3, 0, 'h400), sd(2, 0, 16), ld(4, 0, 16),
              srli(5, 4, 32), sd(5, 0, 'h400), srai(6, 4, 63), sd(6, 0, 'h400), addi(10, 0, 2047),
              addi(10, 10, 1), ld(11, 10, 16), srli(12, 11, 60), sd(12, 0, 'h400), jal(0, 0)};
      exp_q = {32'h1, 32'h8000_0000, 32'hffff_ffff, 32'h8};
      run("shift63", 30, 1'b1);
      prog = {addi(1, 0, 4), sd(1, 0, 'h400), addi(2, 0, 1), rr(0, 3, 0, 0, 0), sd(2, 0, 'h400), jal(0, 0)};
      exp_q = {32'h4, 32'h1};
      run("passfail", 20, 1'b1);
      prog = {addi(0, 0, 5), sd(0, 0, 'h400), 32'h0, addi(7, 0, 9), sd(7, 0, 'h400), jal(0, 0)};
      exp_q = {32'h0, 32'h9};
      run("x0_nop", 20, 1'b1);
      prog = {addi(1, 0, 'h12), addi(2, 0, 'h34), sd(1, 0, 'h400), sd(2, 0, 'h400), jal(0, 0)};
      exp_q = {32'h12, 32'h34};
      run("b2b", 20, 1'b1);
      prog = {addi(1, 0, -3), addi(2, 0, 2), br(4, 1, 2, 8), sd(1, 0, 'h400), br(1, 1, 2, 8), sd(1, 0, 'h400),
              rr('h20, 3, 2, 1, 0), sd(3, 0, 'h400), jal(5, 8), sd(1, 0, 'h400), sd(5, 0, 'h400),
              ut('h12345, 6, 'h37), it('hff, 6, 4, 6, 'h13), sd(6, 0, 'h400), ut(0, 7, 'h17), it(17, 7, 0, 8, 'h67),
              sd(1, 0, 'h400), sd(1, 0, 'h400), sd(8, 0, 'h400), br(5, 2, 1, 8), sd(1, 0, 'h400), br(0, 1, 2, 8),
              sd(2, 0, 'h400), ld(9, 0, 'h400), addi(9, 9, 1), sd(9, 0, 'h400), jal(0, 0)};
      exp_q = {32'h5, 32'h24, 32'h1234_50ff, 32'h40, 32'h2, 32'h3};
      run("ctrl", 60, 1'b1);
      chk("pre_reset_gpio", 64'(gpio), 64'h3);
      rst = 1'b1;
      @(negedge clk);
      chk("midreset_pc", dut.pc, 64'd0);
      chk("midreset_cs", 64'(cs), 64'd0);
      chk("midreset_gpio", 64'(gpio), 64'd0);
      exp_q = {32'h5, 32'h24, 32'h1234_50ff, 32'h40, 32'h2, 32'h3};
      run("restart", 60, 1'b0);
      trst = 1'b1;
      #2 trst = 1'b0;
      tck_pulse(1'b1);
      chk("jtag_tdo1", 64'(tdo), 64'd1);
      tck_pulse(1'b0);
      chk("jtag_tdo0", 64'(tdo), 64'd0);
      tck_pulse(1'b1);
      trst = 1'b1;
      #1;
      chk("jtag_trst", 64'(tdo), 64'd0);
      trst = 1'b0;
      repeat (5) @(negedge clk);
      chk("jtag_no_cs", 64'(cs), 64'd0);
      chk("jtag_gpio_kept", 64'(gpio), 64'h3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
